// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers (start/busy/done handshake).
// Define MULDIV_FAST_MUL_EN to make MULT/MULTU single-cycle; DIV stays iterative.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // hacc: product high half / partial remainder; lacc: multiplier bits / dividend->quotient
    logic [WIDTH-1:0] hacc_q, hacc_d;
    logic [WIDTH-1:0] lacc_q, lacc_d;
    logic [WIDTH-1:0] opr_q, opr_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic             isdiv_q, isdiv_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic             signed_op, sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
        signed_op = ~op[0];
        sgn_a     = signed_op & a[WIDTH-1];
        sgn_b     = signed_op & b[WIDTH-1];
        mag_a     = sgn_a ? -a : a;
        mag_b     = sgn_b ? -b : b;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod, fast_fix;
    always_comb begin
        fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
        fast_fix  = (sgn_a ^ sgn_b) ? -fast_prod : fast_prod;
    end
`endif

    always_comb begin
        mul_sum = {1'b0, hacc_q} + (lacc_q[0] ? {1'b0, opr_q} : {(WIDTH+1){1'b0}});
        div_sh  = {hacc_q, lacc_q[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, opr_q};
        div_rem = div_ge ? (div_sh[WIDTH-1:0] - opr_q) : div_sh[WIDTH-1:0];

        prod     = {hacc_q, lacc_q};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;
        // A zero divisor leaves |a| in the remainder, so only the quotient needs overriding
        quo_fix  = div0_q ? {WIDTH{1'b1}} : ((sa_q ^ sb_q) ? -lacc_q : lacc_q);
        rem_fix  = sa_q ? -hacc_q : hacc_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hacc_d  = hacc_q;
        lacc_d  = lacc_q;
        opr_d   = opr_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        isdiv_d = isdiv_q;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                                {hi_d, lo_d} = fast_fix;
                                done_d       = 1'b1;
`else
                                state_d = S_CALC;
                                cnt_d   = '0;
                                hacc_d  = '0;
                                lacc_d  = mag_b;
                                opr_d   = mag_a;
                                sa_d    = sgn_a;
                                sb_d    = sgn_b;
                                isdiv_d = 1'b0;
                                div0_d  = 1'b0;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                state_d = S_CALC;
                                cnt_d   = '0;
                                hacc_d  = '0;
                                lacc_d  = mag_a;
                                opr_d   = mag_b;
                                sa_d    = sgn_a;
                                sb_d    = sgn_b;
                                isdiv_d = 1'b1;
                                div0_d  = (b == '0);
                            end
                            OP_MTHI: hi_d = a;
                            OP_MTLO: lo_d = a;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (isdiv_q) begin
                        hacc_d = div_rem;
                        lacc_d = {lacc_q[WIDTH-2:0], div_ge};
                    end else begin
                        hacc_d = mul_sum[WIDTH:1];
                        lacc_d = {mul_sum[0], lacc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIXUP;
                end
                S_FIXUP: begin
                    if (isdiv_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hacc_q  <= '0;
            lacc_q  <= '0;
            opr_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            isdiv_q <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hacc_q  <= hacc_d;
            lacc_q  <= lacc_d;
            opr_q   <= opr_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            isdiv_q <= isdiv_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural HI/LO effect of one accepted op
    task automatic ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: if (y == 0) begin m_lo = '1; m_hi = x; end
                  else begin q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0]; end
            3'd3: if (y == 0) begin m_lo = '1; m_hi = x; end
                  else begin m_lo = x / y; m_hi = x % y; end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    function automatic bit is_fast_mul(input logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
        return o == 3'd0 || o == 3'd1;
`else
        return (o == 3'd7) && (o == 3'd0);
`endif
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        ref_op(o, x, y);
        if (o >= 3'd4 || is_fast_mul(o)) begin
            chk("imm_busy", busy, 0);
            chk("imm_done", done, is_fast_mul(o));
            chk("imm_hi", hi, m_hi);
            chk("imm_lo", lo, m_lo);
            return;
        end
        chk("busy_after_accept", busy, 1);
        cyc = 0;
        while (!done && cyc < W + 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, W + 1);
        chk("busy_at_done", busy, 0);
        chk("res_hi", hi, m_hi);
        chk("res_lo", lo, m_lo);
    endtask

    function automatic logic [W-1:0] rnd_val();
        logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        int s = $urandom_range(0, 3);
        if (s == 0) return corners[$urandom_range(0, 4)];
        if (s == 1) return W'($urandom_range(0, 300));
        if (s == 2) return -W'($urandom_range(1, 300));
        return $urandom;
    endfunction

    initial begin
        logic [W-1:0] h0, l0;
        #12;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(negedge clk); rst_n = 1'b1;

        run_op(3'd0, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFFA);
        run_op(3'd1, 32'hFFFFFFFE, 32'd3);
        chk("multu_hi", hi, 32'h2); chk("multu_lo", lo, 32'hFFFFFFFA);
        run_op(3'd2, -32'd7, 32'd2);
        chk("div_lo", lo, 32'hFFFFFFFD); chk("div_hi", hi, 32'hFFFFFFFF);
        run_op(3'd3, 32'd7, 32'd2);
        chk("divu_lo", lo, 32'd3); chk("divu_hi", hi, 32'd1);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        chk("divovf_lo", lo, 32'h80000000); chk("divovf_hi", hi, 32'h0);
        run_op(3'd3, 32'h1234, 32'd0);
        chk("div0_lo", lo, 32'hFFFFFFFF); chk("div0_hi", hi, 32'h1234);
        run_op(3'd2, -32'd9, 32'd0);
        run_op(3'd5, 32'hA5A5A5A5, 32'd0);
        run_op(3'd4, 32'h5A5A5A5A, 32'd0);
        chk("mtlo_lo", lo, 32'hA5A5A5A5); chk("mthi_hi", hi, 32'h5A5A5A5A);
        run_op(3'd6, 32'h11111111, 32'h2);

        // flush with start in IDLE drops the request
        @(negedge clk); start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        chk("flush_start_hi", hi, m_hi);
        chk("flush_start_busy", busy, 0);

        // flush mid-CALC: cancel, no done, HI/LO untouched
        h0 = hi; l0 = lo;
        @(negedge clk); start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy", busy, 0);
        begin
            int seen = 0;
            repeat (W + 4) begin @(posedge clk); #1; if (done) seen++; end
            chk("flush_no_done", seen, 0);
        end
        chk("flush_hi", hi, h0);
        chk("flush_lo", lo, l0);

        // start while busy is ignored
        @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd9;
        @(posedge clk); #1; start = 1'b0;
        ref_op(3'd3, 32'd100, 32'd9);
        repeat (3) @(posedge clk);
        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        begin
            int cyc = 4;
            while (!done && cyc < W + 10) begin @(posedge clk); #1; cyc++; end
            chk("busy_start_lat", cyc, W + 1);
        end
        chk("busy_start_hi", hi, m_hi);
        chk("busy_start_lo", lo, m_lo);

        // async reset mid-CALC
        @(negedge clk); start = 1'b1; op = 3'd2; a = 32'd12345; b = 32'd17;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        chk("rst_mid_hi", hi, 0); chk("rst_mid_lo", lo, 0);
        chk("rst_mid_busy", busy, 0); chk("rst_mid_done", done, 0);
        m_hi = '0; m_lo = '0;
        @(negedge clk); rst_n = 1'b1;

`ifdef MULDIV_FAST_MUL_EN
        run_op(3'd0, 32'd6, 32'd7);
        chk("fast_lo", lo, 32'd42);
`endif

        for (int i = 0; i < 40; i++) run_op(3'($urandom_range(0, 6)), rnd_val(), rnd_val());

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
